// File: rtl/tt_sweep_capture_pkg.sv
// Shared types and sizes for the truth-table sweep/capture stage.
package tt_pkg;

  localparam int TT_VEC_W = 3;
  localparam int TT_ROWS  = 8;
  localparam int TT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } tt_state_t;

endpackage

// File: rtl/tt_sweep_capture_if.sv
// Control and gate-side signals of the sweep/capture stage; master is the environment, slave the stage.
interface tt_sweep_capture_if;
  import tt_pkg::*;

  logic               start;
  logic               dut_out;
  logic               in1;
  logic               in2;
  logic               in3;
  logic               busy;
  logic               done;
  logic               pass;
  logic [TT_ROWS-1:0] tt_observed;
  logic [TT_ROWS-1:0] error_mask;

  modport master (
    output start, dut_out,
    input  in1, in2, in3, busy, done, pass, tt_observed, error_mask
  );

  modport slave (
    input  start, dut_out,
    output in1, in2, in3, busy, done, pass, tt_observed, error_mask
  );

endinterface

// File: rtl/tt_sweep_capture_sync2.sv
// Two-flop synchronizer bringing the asynchronous gate output into the clk domain.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/tt_sweep_capture.sv
// Drives a 3-input gate through all 8 vectors, captures its output per vector and
// compares the observed truth table against EXPECTED_TT.
module tt_sweep_capture
  import tt_pkg::*;
#(
  parameter int unsigned        SETTLE_CYCLES = 4,
  parameter logic [TT_ROWS-1:0] EXPECTED_TT   = 8'hBA
) (
  input logic          clk,
  input logic          rst_n,
  tt_sweep_capture_if.slave bus
);

  localparam logic [TT_CNT_W-1:0] CNT_LAST = TT_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [TT_VEC_W-1:0] VEC_LAST = TT_VEC_W'(TT_ROWS - 1);

  tt_state_t           state, state_nxt;
  logic [TT_VEC_W-1:0] vec, vec_nxt;
  logic [TT_CNT_W-1:0] cnt, cnt_nxt;
  logic [TT_ROWS-1:0]  tt_obs, tt_obs_nxt;
  logic [TT_ROWS-1:0]  err_mask, err_mask_nxt;
  logic                pass_r, pass_nxt;
  logic                dut_sync;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.dut_out),
    .q     (dut_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      vec      <= '0;
      cnt      <= '0;
      tt_obs   <= '0;
      err_mask <= '0;
      pass_r   <= 1'b0;
    end else begin
      state    <= state_nxt;
      vec      <= vec_nxt;
      cnt      <= cnt_nxt;
      tt_obs   <= tt_obs_nxt;
      err_mask <= err_mask_nxt;
      pass_r   <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    vec_nxt      = vec;
    cnt_nxt      = cnt;
    tt_obs_nxt   = tt_obs;
    err_mask_nxt = err_mask;
    pass_nxt     = pass_r;
    case (state)
      IDLE: begin
        if (bus.start) begin
          vec_nxt      = '0;
          cnt_nxt      = '0;
          tt_obs_nxt   = '0;
          err_mask_nxt = '0;
          pass_nxt     = 1'b0;
          state_nxt    = SETTLE;
        end
      end
      SETTLE: begin
        cnt_nxt = cnt + TT_CNT_W'(1);
        if (cnt == CNT_LAST) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        tt_obs_nxt[vec] = dut_sync;
        if (vec == VEC_LAST) begin
          // Compare against the table that already includes this last row, so
          // pass/error_mask are valid in the same cycle that done is raised.
          pass_nxt     = (tt_obs_nxt == EXPECTED_TT);
          err_mask_nxt = tt_obs_nxt ^ EXPECTED_TT;
          vec_nxt      = '0;
          state_nxt    = DONE;
        end else begin
          vec_nxt   = vec + TT_VEC_W'(1);
          cnt_nxt   = '0;
          state_nxt = SETTLE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.in1         = vec[2];
  assign bus.in2         = vec[1];
  assign bus.in3         = vec[0];
  assign bus.busy        = (state == SETTLE) || (state == SAMPLE);
  assign bus.done        = (state == DONE);
  assign bus.pass        = pass_r;
  assign bus.tt_observed = tt_obs;
  assign bus.error_mask  = err_mask;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench for tt_sweep_capture: two instances (SETTLE_CYCLES 4 and 2) checked
// every cycle against a cycle-count model, plus hand-computed literal expectations.
module tb_tt_sweep_capture;

  localparam int        SC0 = 4;
  localparam int        SC1 = 2;
  localparam logic [7:0] EXP = 8'hBA;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  tt_sweep_capture_if ifc0 ();
  tt_sweep_capture_if ifc1 ();

  tt_sweep_capture #(.SETTLE_CYCLES(SC0), .EXPECTED_TT(EXP)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc0)
  );

  tt_sweep_capture #(.SETTLE_CYCLES(SC1), .EXPECTED_TT(EXP)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Gate models: instance 0 is combinational, instance 1 settles just under one clock later.
  logic [7:0] gtt [2];
  logic [2:0] v0, v1;
  logic       d1 = 1'b0;

  assign v0 = {ifc0.in1, ifc0.in2, ifc0.in3};
  assign v1 = {ifc1.in1, ifc1.in2, ifc1.in3};
  assign ifc0.dut_out = gtt[0][v0];
  assign ifc1.dut_out = d1;

  always begin
    @(v1);
    #8;
    d1 = gtt[1][v1];
  end

  // Model: k = cycles since the accepting edge (0 = idle); everything follows from k.
  int          m_k   [2];
  bit          m_fin [2];
  bit [7:0]    m_tbl [2];
  logic        st_v  [2];
  logic        a_busy[2], a_done[2], a_pass[2];
  logic [2:0]  a_vec [2];
  logic [7:0]  a_obs [2], a_mask[2];

  assign st_v[0] = ifc0.start;  assign st_v[1] = ifc1.start;
  assign a_busy[0] = ifc0.busy; assign a_busy[1] = ifc1.busy;
  assign a_done[0] = ifc0.done; assign a_done[1] = ifc1.done;
  assign a_pass[0] = ifc0.pass; assign a_pass[1] = ifc1.pass;
  assign a_vec[0]  = v0;        assign a_vec[1]  = v1;
  assign a_obs[0]  = ifc0.tt_observed; assign a_obs[1]  = ifc1.tt_observed;
  assign a_mask[0] = ifc0.error_mask;  assign a_mask[1] = ifc1.error_mask;

  function automatic int sc_of(int i);
    return (i == 0) ? SC0 : SC1;
  endfunction

  function automatic int n_done(int i);
    return 8 * (sc_of(i) + 1) + 1;
  endfunction

  function automatic bit e_busy(int k, int i);
    return (k >= 1) && (k < n_done(i));
  endfunction

  function automatic bit e_final(int k, int i, bit fin);
    return (k == n_done(i)) || ((k == 0) && fin);
  endfunction

  function automatic logic [2:0] e_vec(int k, int i);
    return e_busy(k, i) ? 3'((k - 1) / (sc_of(i) + 1)) : 3'd0;
  endfunction

  function automatic logic [7:0] e_obs(int k, int i, bit [7:0] tbl, bit fin);
    logic [7:0] r;
    r = 8'h00;
    if (k == 0) return fin ? tbl : 8'h00;
    for (int v = 0; v < 8; v++)
      if (k > (v + 1) * (sc_of(i) + 1)) r[v] = tbl[v];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_k[i]   <= 0;
        m_fin[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_k[i] == 0) begin
          if (st_v[i]) begin
            m_k[i]   <= 1;
            m_fin[i] <= 1'b0;
            m_tbl[i] <= gtt[i];
          end
        end else if (m_k[i] == n_done(i)) begin
          m_k[i]   <= 0;
          m_fin[i] <= 1'b1;
        end else begin
          m_k[i] <= m_k[i] + 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      int k;
      bit fin;
      k   = m_k[i];
      fin = e_final(k, i, m_fin[i]);
      chk($sformatf("busy%0d", i), a_busy[i], e_busy(k, i));
      chk($sformatf("done%0d", i), a_done[i], k == n_done(i));
      chk($sformatf("vec%0d", i),  a_vec[i],  e_vec(k, i));
      chk($sformatf("obs%0d", i),  a_obs[i],  e_obs(k, i, m_tbl[i], m_fin[i]));
      chk($sformatf("pass%0d", i), a_pass[i], fin ? (m_tbl[i] == EXP) : 1'b0);
      chk($sformatf("mask%0d", i), a_mask[i], fin ? (m_tbl[i] ^ EXP) : 8'h00);
    end
  end

  // Starts a sweep on instance 0 from IDLE (called #1 after an edge) and returns in the done cycle.
  task automatic sweep0(output int cyc, input int start_at, input bit start_in_done);
    ifc0.start = 1'b1;
    @(posedge clk); #1;
    ifc0.start = 1'b0;
    cyc = 1;
    chk("clr_obs0", ifc0.tt_observed, 8'h00);
    chk("clr_pass0", ifc0.pass, 1'b0);
    chk("clr_mask0", ifc0.error_mask, 8'h00);
    while (!ifc0.done && cyc < 200) begin
      ifc0.start = (start_at != 0 && cyc == start_at);
      @(posedge clk); #1;
      cyc++;
    end
    ifc0.start = 1'b0;
    chk("done_seen0", ifc0.done, 1'b1);
    if (start_in_done) begin
      ifc0.start = 1'b1;
      @(posedge clk); #1;
      ifc0.start = 1'b0;
    end
  endtask

  initial begin
    int cyc;
    int dn;
    ifc0.start = 1'b0;
    ifc1.start = 1'b0;
    gtt[0] = 8'hBA;
    gtt[1] = 8'hBA;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", ifc0.busy, 1'b0);
    chk("rst_done", ifc0.done, 1'b0);
    chk("rst_pass", ifc0.pass, 1'b0);
    chk("rst_obs", ifc0.tt_observed, 8'h00);
    chk("rst_mask", ifc0.error_mask, 8'h00);
    chk("rst_vec", v0, 3'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Correct gate 8'hBA
    sweep0(cyc, 0, 1'b0);
    chk("lat_a", cyc, 41);
    chk("pass_a", ifc0.pass, 1'b1);
    chk("obs_a", ifc0.tt_observed, 8'hBA);
    chk("mask_a", ifc0.error_mask, 8'h00);
    chk("vec_done_a", v0, 3'd0);
    @(posedge clk); #1;
    chk("pass_hold_a", ifc0.pass, 1'b1);
    chk("obs_hold_a", ifc0.tt_observed, 8'hBA);

    // Row 6 stuck at 1
    gtt[0] = 8'hFA;
    sweep0(cyc, 0, 1'b0);
    chk("pass_b", ifc0.pass, 1'b0);
    chk("obs_b", ifc0.tt_observed, 8'hFA);
    chk("mask_b", ifc0.error_mask, 8'h40);
    @(posedge clk); #1;

    // start at cycle 10 and in the DONE cycle are both ignored
    gtt[0] = 8'hBA;
    sweep0(cyc, 10, 1'b1);
    chk("lat_c", cyc, 41);
    dn = 0;
    repeat (50) begin
      if (ifc0.done) dn++;
      @(posedge clk); #1;
    end
    chk("extra_done_c", dn, 0);
    chk("obs_hold_c", ifc0.tt_observed, 8'hBA);
    chk("pass_hold_c", ifc0.pass, 1'b1);

    // Reset in the middle of a sweep
    ifc0.start = 1'b1;
    @(posedge clk); #1;
    ifc0.start = 1'b0;
    cyc = 1;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("obs_partial", ifc0.tt_observed, 8'h02);
    chk("vec_c20", v0, 3'd3);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", ifc0.busy, 1'b0);
    chk("abort_vec", v0, 3'd0);
    chk("abort_obs", ifc0.tt_observed, 8'h00);
    chk("abort_pass", ifc0.pass, 1'b0);
    chk("abort_done", ifc0.done, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dn = 0;
    repeat (45) begin
      @(posedge clk); #1;
      if (ifc0.done || ifc0.busy) dn++;
    end
    chk("no_resume", dn, 0);
    sweep0(cyc, 0, 1'b0);
    chk("lat_d", cyc, 41);
    chk("pass_d", ifc0.pass, 1'b1);
    chk("obs_d", ifc0.tt_observed, 8'hBA);

    // Back-to-back: start in the first IDLE cycle after done
    @(posedge clk); #1;
    sweep0(cyc, 0, 1'b0);
    chk("lat_e", cyc, 41);
    chk("pass_e", ifc0.pass, 1'b1);

    // SETTLE_CYCLES=2 with a delayed gate
    @(posedge clk); #1;
    ifc1.start = 1'b1;
    @(posedge clk); #1;
    ifc1.start = 1'b0;
    cyc = 1;
    while (!ifc1.done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen1", ifc1.done, 1'b1);
    chk("lat_f", cyc, 25);
    chk("pass_f", ifc1.pass, 1'b1);
    chk("obs_f", ifc1.tt_observed, 8'hBA);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
